// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronizes the raw line, checks each 11-bit frame
// and buffers accepted scan-code bytes in a first-word-fall-through FIFO.
module ps2_rx_fifo #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [2:0]    clk_sync_q;
    logic [2:0]    data_sync_q;
    // Holds the ten most recent bits; the arriving bit completes the 11-bit frame.
    logic [9:0]    frame_q;
    logic [3:0]    bit_cnt_q;
    logic [TW-1:0] timer_q;
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic          overflow_q;
    logic          frame_err_q;

    logic          fall;
    logic [10:0]   frame_next;
    logic          frame_done;
    logic          frame_ok;
    logic          timed_out;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          write;

    always_comb begin
        fall       = clk_sync_q[2] & ~clk_sync_q[1];
        frame_next = {data_sync_q[2], frame_q};
        frame_done = fall && (bit_cnt_q == 4'd10);
        // Start low, stop high, odd parity over data plus parity bit.
        frame_ok   = ~frame_next[0] & frame_next[10] & (^frame_next[9:1]);
        timed_out  = (bit_cnt_q != 4'd0) && !fall && (timer_q == TW'(TIMEOUT - 1));
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = nextdata & ~empty;
        push       = frame_done & frame_ok;
        // A same-cycle pop frees the slot, so a full FIFO still accepts the byte.
        write      = push & (~full | pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 3'b111;
            frame_q     <= '0;
            bit_cnt_q   <= '0;
            timer_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
            data_sync_q <= {data_sync_q[1:0], ps2_data};
            frame_err_q <= frame_done & ~frame_ok;

            if (fall) begin
                frame_q   <= frame_next[10:1];
                timer_q   <= '0;
                bit_cnt_q <= frame_done ? 4'd0 : bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == 4'd0) begin
                timer_q <= '0;
            end else if (timed_out) begin
                bit_cnt_q <= 4'd0;
                timer_q   <= '0;
            end else begin
                timer_q <= timer_q + 1'b1;
            end

            if (write) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (write) begin
            mem_q[wr_ptr_q[AW-1:0]] <= frame_next[8:1];
        end
    end

    assign ready     = ~empty;
    assign data      = ready ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of buffered scan-code bytes (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 50000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous to clk.
REQ-007 SHALL have port nextdata  input  1  consumer pop strobe, active-high, one byte per cycle it is high.
REQ-008 SHALL have port data  output  8  byte at the FIFO head, first-word-fall-through.
REQ-009 SHALL have port ready  output  1  high when the FIFO holds at least one byte.
REQ-010 SHALL have port overflow  output  1  sticky flag: a valid byte was dropped because the FIFO was full.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse when a completed frame fails its checks.

Function
REQ-012 SHALL pass ps2_clk and ps2_data each through a 3-flop synchronizer; a falling edge is detected when the last two ps2_clk stages read 1 then 0.
REQ-013 SHALL sample synchronized ps2_data on each detected falling edge and shift it into an 11-bit frame register, LSB first.
REQ-014 SHALL use a 4-bit bit counter: 0 idle, incremented on each falling edge, and frame evaluated when the 11th bit (counter 10) is captured.
REQ-015 SHALL accept a frame only if start bit = 0, stop bit = 1, and the XOR of 8 data bits and the parity bit = 1 (odd parity).
REQ-016 SHALL, in the cycle after the 11th edge is detected, push an accepted byte into the FIFO (ready/data updated that same cycle).
REQ-017 SHALL, on a rejected frame, assert frame_err for exactly one cycle, discard the byte, and leave the FIFO unchanged.
REQ-018 SHALL return the bit counter to 0 after every evaluated frame, whether accepted or rejected.
REQ-019 SHALL count clk cycles while the bit counter is nonzero and no falling edge occurs; at TIMEOUT it SHALL return the bit counter to 0 silently (no frame_err).
REQ-020 SHALL implement the FIFO with read/write pointers one bit wider than log2(FIFO_DEPTH); empty when equal, full when the MSBs differ and the rest match.
REQ-021 SHALL drive data with the head entry whenever ready=1; data is don't-care when ready=0.
REQ-022 SHALL pop one entry per cycle with nextdata=1 and ready=1; nextdata while empty SHALL be ignored with no pointer change.
REQ-023 SHALL, on simultaneous push and pop, perform both; when full, a same-cycle pop frees the slot so the push succeeds with no overflow.
REQ-024 SHALL, on a push while full without a same-cycle pop, drop the new byte, keep FIFO contents, and set overflow.
REQ-025 SHALL hold overflow set until reset; pops do not clear it.

Reset
REQ-026 SHALL, on rst=0, immediately clear synchronizers to 1, shift register, bit counter, timeout counter, FIFO pointers, overflow and frame_err, independent of clk.
REQ-027 SHALL drive ready=0, overflow=0, frame_err=0 and data=8'h00 while in reset.
REQ-028 SHALL discard a partially received frame when reset asserts mid-frame; reception restarts with the next start bit after release.

Verification
REQ-029 SHALL pass: frame 0,0,0,1,1,1,0,0,0,0(parity),1 (0x1C) -> ready=1 and data=8'h1C one cycle after the 11th falling edge; nextdata pulse -> ready=0.
REQ-030 SHALL pass: 0x1C frame with parity bit 1 -> frame_err high exactly one cycle, ready stays 0.
REQ-031 SHALL pass: 9 valid frames 0x01..0x09 with no pops, FIFO_DEPTH=8 -> overflow=1 after the 9th; eight pops return 0x01..0x08 in order, then ready=0.
REQ-032 SHALL pass: FIFO full plus nextdata coinciding with the push cycle of 0x5A -> overflow stays 0, last entry read out is 0x5A.
REQ-033 SHALL pass: 5 bits then silence of TIMEOUT+10 cycles, then full frame 0xF0 -> data=8'hF0, frame_err never asserted.
REQ-034 SHALL pass: rst low after 6 bits of a frame, released, then frame 0x29 -> only 0x29 delivered, ready=0 throughout reset.
